// File: rtl/cdb_writeback_if.sv
// Bundle of the three unit result ports, their ready/occupancy returns and the
// common data bus broadcast. slave is the writeback stage, master the environment.
interface cdb_writeback_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              f0_valid, f1_valid, f3_valid;
  logic [TAG_W-1:0]  f0_tag,   f1_tag,   f3_tag;
  logic [DATA_W-1:0] f0_value, f1_value, f3_value;
  logic              f0_ready, f1_ready, f3_ready;
  logic [CNT_W-1:0]  f0_count, f1_count, f3_count;

  logic              cdb_hold;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic [1:0]        cdb_unit;

  modport master (
    output f0_valid, f0_tag, f0_value, f1_valid, f1_tag, f1_value,
           f3_valid, f3_tag, f3_value, cdb_hold,
    input  f0_ready, f1_ready, f3_ready, f0_count, f1_count, f3_count,
           cdb_valid, cdb_tag, cdb_value, cdb_unit
  );

  modport slave (
    input  f0_valid, f0_tag, f0_value, f1_valid, f1_tag, f1_value,
           f3_valid, f3_tag, f3_value, cdb_hold,
    output f0_ready, f1_ready, f3_ready, f0_count, f1_count, f3_count,
           cdb_valid, cdb_tag, cdb_value, cdb_unit
  );
endinterface

// File: rtl/cdb_writeback.sv
// Result writeback: one small FIFO per functional unit, F3-priority / F0-F1
// round-robin arbitration onto a single registered common data bus.
module cdb_wb_fifo #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_vld,
  input  logic [TAG_W-1:0]            push_tag,
  input  logic [DATA_W-1:0]           push_val,
  input  logic                        pop,
  output logic                        rdy,
  output logic [TAG_W-1:0]            head_tag,
  output logic [DATA_W-1:0]           head_val,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push;

  // Ready looks only at the registered count, never at this cycle's pop.
  assign rdy      = (cnt_q != CNT_W'(DEPTH));
  assign push     = push_vld && rdy;
  assign head_tag = mem_q[rp_q].tag;
  assign head_val = mem_q[rp_q].value;
  assign count    = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = '{tag: push_tag, value: push_val};
      wp_d        = wp_q + PTR_W'(1);
    end
    if (pop) rp_d = rp_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

module cdb_writeback #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  cdb_writeback_if.slave bus
);
  localparam int NUM_LANES = 3;
  localparam int CNT_W     = $clog2(DEPTH) + 1;
  // Lane 2 carries F3; its bus id is 3.
  localparam logic [NUM_LANES-1:0][1:0] UNIT_ID = {2'd3, 2'd1, 2'd0};

  logic [NUM_LANES-1:0]             lane_vld, lane_rdy, lane_pop, lane_ne;
  logic [NUM_LANES-1:0][TAG_W-1:0]  lane_tag, head_tag;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_val, head_val;
  logic [NUM_LANES-1:0][CNT_W-1:0]  lane_cnt;

  logic              rr_q, rr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [1:0]        cdb_unit_q, cdb_unit_d;

  assign lane_vld = {bus.f3_valid, bus.f1_valid, bus.f0_valid};
  assign lane_tag = {bus.f3_tag,   bus.f1_tag,   bus.f0_tag};
  assign lane_val = {bus.f3_value, bus.f1_value, bus.f0_value};
  assign {bus.f3_ready, bus.f1_ready, bus.f0_ready} = lane_rdy;
  assign bus.f0_count = lane_cnt[0];
  assign bus.f1_count = lane_cnt[1];
  assign bus.f3_count = lane_cnt[2];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cdb_wb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (lane_vld[i]),
      .push_tag (lane_tag[i]),
      .push_val (lane_val[i]),
      .pop      (lane_pop[i]),
      .rdy      (lane_rdy[i]),
      .head_tag (head_tag[i]),
      .head_val (head_val[i]),
      .count    (lane_cnt[i])
    );
    assign lane_ne[i] = (lane_cnt[i] != '0);
  end

  // rr points at the F0/F1 unit that wins a tie; it moves off whoever was granted.
  always_comb begin
    lane_pop = '0;
    rr_d     = rr_q;
    if (!bus.cdb_hold) begin
      if (lane_ne[2]) begin
        lane_pop[2] = 1'b1;
      end else if (lane_ne[0] && (!lane_ne[1] || !rr_q)) begin
        lane_pop[0] = 1'b1;
        rr_d        = 1'b1;
      end else if (lane_ne[1]) begin
        lane_pop[1] = 1'b1;
        rr_d        = 1'b0;
      end
    end
  end

  always_comb begin
    cdb_valid_d = |lane_pop;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_unit_d  = cdb_unit_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_pop[i]) begin
        cdb_tag_d   = head_tag[i];
        cdb_value_d = head_val[i];
        cdb_unit_d  = UNIT_ID[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_unit_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_unit_q  <= cdb_unit_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_unit  = cdb_unit_q;
endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: per-cycle vector table plus hand-written
// back-pressure, reset and round-robin sequences.
module tb_cdb_writeback;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_writeback_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();
  cdb_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // v bit0=F0, bit1=F1, bit2=F3; e* = bus after the edge; c* = counts after the edge.
  typedef struct {
    int v, t0, d0, t1, d1, t3, d3, hold;
    int ev, et, ed, eu, c0, c1, c3;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input int v, t0, d0, t1, d1, t3, d3, hold,
                     input int ev, et, ed, eu, c0, c1, c3);
    vec_t r;
    r = '{v, t0, d0, t1, d1, t3, d3, hold, ev, et, ed, eu, c0, c1, c3};
    vecs.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input int v, t0, d0, t1, d1, t3, d3, hold);
    bus.f0_valid = v[0];
    bus.f0_tag   = TAG_W'(t0);
    bus.f0_value = DATA_W'(d0);
    bus.f1_valid = v[1];
    bus.f1_tag   = TAG_W'(t1);
    bus.f1_value = DATA_W'(d1);
    bus.f3_valid = v[2];
    bus.f3_tag   = TAG_W'(t3);
    bus.f3_value = DATA_W'(d3);
    bus.cdb_hold = hold[0];
  endtask

  task automatic expect_out(input string nm, input int chk_bus,
                            input int ev, et, ed, eu, c0, c1, c3);
    chk({nm, " cdb_valid"}, 32'(bus.cdb_valid), ev);
    if (chk_bus != 0) begin
      chk({nm, " cdb_tag"},   32'(bus.cdb_tag),   et);
      chk({nm, " cdb_value"}, 32'(bus.cdb_value), ed);
      chk({nm, " cdb_unit"},  32'(bus.cdb_unit),  eu);
    end
    chk({nm, " f0_count"}, 32'(bus.f0_count), c0);
    chk({nm, " f1_count"}, 32'(bus.f1_count), c1);
    chk({nm, " f3_count"}, 32'(bus.f3_count), c3);
    chk({nm, " f0_ready"}, 32'(bus.f0_ready), (c0 != DEPTH) ? 1 : 0);
    chk({nm, " f1_ready"}, 32'(bus.f1_ready), (c1 != DEPTH) ? 1 : 0);
    chk({nm, " f3_ready"}, 32'(bus.f3_ready), (c3 != DEPTH) ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held two cycles with F0 pushing: nothing captured.
    drive_in(1, 15, 'hFFFF, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    step();
    expect_out("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("post-reset%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Contention: F3 first, then F0 (rr=0), then F1.
    add(7, 1, 'h11, 2, 'h22, 4, 'hC8, 0,  0, 0, 0, 0,      1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 4, 'hC8, 3,   1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 'h11, 0,   0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 2, 'h22, 1,   0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 0, 0);
    // Single result: visible two edges after the push, one cycle only.
    add(1, 3, 'h0005, 0, 0, 0, 0, 0,      0, 0, 0, 0,      1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 3, 'h0005, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 0, 0);
    // Repeat pair: rr now favours F1.
    add(3, 8, 'h88, 9, 'h99, 0, 0, 0,     0, 0, 0, 0,      1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 9, 'h99, 1,   1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 8, 'h88, 0,   0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 0, 0);
    // Push and pop on F0 in the same cycle.
    add(1, 10, 'hA0, 0, 0, 0, 0, 0,       0, 0, 0, 0,      1, 0, 0);
    add(1, 11, 'hB0, 0, 0, 0, 0, 0,       1, 10, 'hA0, 0,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 11, 'hB0, 0,  0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 0, 0);
    // One hold cycle delays the F3 broadcast by one cycle.
    add(4, 0, 0, 0, 0, 12, 'hC0C, 0,      0, 0, 0, 0,      0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 0,      0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,           1, 12, 'hC0C, 3, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_in(vecs[i].v, vecs[i].t0, vecs[i].d0, vecs[i].t1, vecs[i].d1,
               vecs[i].t3, vecs[i].d3, vecs[i].hold);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ev, vecs[i].et,
                 vecs[i].ed, vecs[i].eu, vecs[i].c0, vecs[i].c1, vecs[i].c3);
    end

    // Back-pressure: F1 fills under hold, tag 7 waits for ready.
    drive_in(2, 0, 0, 5, 'h55, 0, 0, 1);
    step();
    expect_out("bp push5", 0, 0, 0, 0, 0, 0, 1, 0);
    drive_in(2, 0, 0, 6, 'h66, 0, 0, 1);
    step();
    expect_out("bp full", 0, 0, 0, 0, 0, 0, 2, 0);
    drive_in(2, 0, 0, 7, 'h77, 0, 0, 1);
    step();
    expect_out("bp held", 0, 0, 0, 0, 0, 0, 2, 0);
    drive_in(2, 0, 0, 7, 'h77, 0, 0, 0);
    step();
    expect_out("bp pop5", 1, 1, 5, 'h55, 1, 0, 1, 0);
    step();
    expect_out("bp pop6", 1, 1, 6, 'h66, 1, 0, 1, 0);
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_out("bp pop7", 1, 1, 7, 'h77, 1, 0, 0, 0);
    step();
    expect_out("bp idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Lone F0 grant leaves rr favouring F1 ahead of the mid-run reset.
    drive_in(1, 15, 'hF0F0, 0, 0, 0, 0, 0);
    step();
    expect_out("rr prep push", 0, 0, 0, 0, 0, 1, 0, 0);
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_out("rr prep bcast", 1, 1, 15, 'hF0F0, 0, 0, 0, 0);

    // Reset mid-operation discards two buffered F3 results.
    drive_in(4, 0, 0, 0, 0, 13, 'h0D13, 1);
    step();
    expect_out("mid fill1", 0, 0, 0, 0, 0, 0, 0, 1);
    drive_in(4, 0, 0, 0, 0, 14, 'h0E14, 1);
    step();
    expect_out("mid fill2", 0, 0, 0, 0, 0, 0, 0, 2);
    drive_in(0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    step();
    expect_out("mid reset", 1, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("mid drained%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // rr back to F0-first after reset.
    drive_in(3, 1, 'h0101, 2, 'h0202, 0, 0, 0);
    step();
    expect_out("rr push", 0, 0, 0, 0, 0, 1, 1, 0);
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_out("rr first", 1, 1, 1, 'h0101, 0, 0, 1, 0);
    step();
    expect_out("rr second", 1, 1, 2, 'h0202, 1, 0, 0, 0);
    step();
    expect_out("rr idle", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
